tc_timer: RTL and testbench

Memory-mapped countdown timer on the M-stage data bus, one instance per timer window (TC0 at 0x7F00, TC1 at 0x7F10). It consumes the byte enables and lane-aligned write data produced by the store byte-enable stage, via the bridge's window select, and returns read data plus an interrupt request to the CP0 interrupt inputs. It supports one-shot and auto-reload modes and has a read-only COUNT register.

---
 rtl/tc_timer_pkg.sv | 50 +++++
 rtl/tc_timer.sv | 146 ++++++++++++++
 tb/tb_tc_timer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tc_timer_pkg.sv
// Shared constants for the tc_timer countdown timer: register offsets,
// FSM state encodings, MODE codes, CTRL bit positions, window bases and
// the byte-lane merge helper used for register writes.
package tc_timer_pkg;

   // Word offsets within a timer window (addr[3:2] of the bus address)
   localparam logic [1:0] OFF_CTRL   = 2'd0;
   localparam logic [1:0] OFF_PRESET = 2'd1;
   localparam logic [1:0] OFF_COUNT  = 2'd2;
   localparam logic [1:0] OFF_RSVD   = 2'd3;

   // FSM state encodings
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } tc_state_e;

   // MODE codes; codes 2 and 3 behave as one-shot
   localparam logic [1:0] MODE_ONESHOT = 2'd0;
   localparam logic [1:0] MODE_RELOAD  = 2'd1;

   // CTRL bit positions
   localparam int CTRL_EN_BIT  = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_MODE_HI = 2;
   localparam int CTRL_IM_BIT  = 3;

   // Window bases decoded by the bus bridge
   localparam logic [31:0] TC0_BASE = 32'h0000_7F00;
   localparam logic [31:0] TC1_BASE = 32'h0000_7F10;

   // Replace the byte lanes of old_val selected by mask with those of new_val
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  mask);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (mask[i]) begin
            res[8*i +: 8] = new_val[8*i +: 8];
         end else begin
            res[8*i +: 8] = old_val[8*i +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/tc_timer.sv
// tc_timer: memory-mapped countdown timer with one-shot and auto-reload
// modes, a read-only COUNT register and a maskable interrupt flag.
// Build option: define TC_BYTE_WRITE_EN to allow per-byte register writes;
// without it only full-word writes (byteen == 4'b1111) are accepted.
module tc_timer
   import tc_timer_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        sel,
   input  logic [1:0]  addr,
   input  logic [3:0]  byteen,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   tc_state_e   state_q, state_d;
   logic [3:0]  ctrl_q, ctrl_d;
   logic [31:0] preset_q, preset_d;
   logic [31:0] count_q, count_d;
   logic        irq_flag_q, irq_flag_d;

   logic [3:0]  wmask_s;
   logic        wr_s;
   logic        ctrl_b0_wr_s;
   logic        preset_wr_s;
   logic        en_s;
   logic        reload_s;

   // Effective byte-lane write mask for this cycle
   always_comb begin
      wmask_s = 4'b0000;
`ifdef TC_BYTE_WRITE_EN
      if (sel) begin
         wmask_s = byteen;
      end else begin
         wmask_s = 4'b0000;
      end
`else
      if (sel && (byteen == 4'b1111)) begin
         wmask_s = 4'b1111;
      end else begin
         wmask_s = 4'b0000;
      end
`endif
   end

   assign wr_s         = (wmask_s != 4'b0000);
   assign ctrl_b0_wr_s = wr_s && (addr == OFF_CTRL) && wmask_s[0];
   assign preset_wr_s  = wr_s && (addr == OFF_PRESET);
   assign en_s         = ctrl_q[CTRL_EN_BIT];
   // Only MODE 1 reloads; MODE 0/2/3 are one-shot
   assign reload_s     = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);

   // FSM next state, counter, irq flag and bus-write merge
   always_comb begin
      state_d    = state_q;
      ctrl_d     = ctrl_q;
      preset_d   = preset_q;
      count_d    = count_q;
      irq_flag_d = irq_flag_q;

      case (state_q)
         ST_IDLE: begin
            if (en_s) begin
               state_d    = ST_LOAD;
               irq_flag_d = 1'b0;
            end else begin
               state_d    = ST_IDLE;
            end
         end
         ST_LOAD: begin
            count_d = preset_q;
            state_d = ST_CNT;
         end
         ST_CNT: begin
            if (!en_s) begin
               state_d = ST_IDLE;
            end else if (count_q == 32'd0) begin
               state_d    = ST_INT;
               irq_flag_d = 1'b1;
            end else begin
               count_d = count_q - 32'd1;
            end
         end
         ST_INT: begin
            if (reload_s) begin
               state_d    = ST_LOAD;
               irq_flag_d = 1'b0;
            end else begin
               ctrl_d[CTRL_EN_BIT] = 1'b0;
               state_d             = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Bus writes come last so they win over the FSM's own updates
      if (ctrl_b0_wr_s) begin
         ctrl_d     = wdata[3:0];
         irq_flag_d = 1'b0;
      end else begin
         ctrl_d     = ctrl_d;
      end

      if (preset_wr_s) begin
         preset_d = merge_bytes(preset_q, wdata, wmask_s);
      end else begin
         preset_d = preset_q;
      end
   end

   // State and register update with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         ctrl_q     <= 4'h0;
         preset_q   <= 32'h0;
         count_q    <= 32'h0;
         irq_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ctrl_q     <= ctrl_d;
         preset_q   <= preset_d;
         count_q    <= count_d;
         irq_flag_q <= irq_flag_d;
      end
   end

   // Zero-latency register read mux
   always_comb begin
      rdata = 32'h0;
      case (addr)
         OFF_CTRL:   rdata = {28'h0, ctrl_q};
         OFF_PRESET: rdata = preset_q;
         OFF_COUNT:  rdata = count_q;
         default:    rdata = 32'h0;
      endcase
   end

   assign irq = irq_flag_q & ctrl_q[CTRL_IM_BIT];

endmodule

// File: tb/tb_tc_timer.sv
// Self-checking bench for tc_timer: a table of single-cycle register
// vectors followed by hand-written multi-cycle timing sequences.
module tb_tc_timer;

   logic        clk;
   logic        reset;
   logic        sel;
   logic [1:0]  addr;
   logic [3:0]  byteen;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   int tests_run = 0;
   int tests_failed = 0;

`ifdef TC_BYTE_WRITE_EN
   localparam bit BW = 1'b1;
`else
   localparam bit BW = 1'b0;
`endif

   tc_timer dut (
      .clk    (clk),
      .reset  (reset),
      .sel    (sel),
      .addr   (addr),
      .byteen (byteen),
      .wdata  (wdata),
      .rdata  (rdata),
      .irq    (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        sel;
      logic [1:0]  addr;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [1:0]  rd_addr;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   vec_t vecs[18];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic bus(input logic s, input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
      @(negedge clk);
      sel = s; addr = a; byteen = be; wdata = d;
      @(posedge clk);
      #1;
      sel = 1'b0; byteen = 4'h0; wdata = 32'h0;
   endtask

   task automatic idle();
      bus(1'b0, 2'd0, 4'h0, 32'h0);
   endtask

   task automatic chk_rd(input string nm, input logic [1:0] a, input logic [31:0] e);
      addr = a;
      #1;
      chk(nm, rdata, e);
   endtask

   task automatic chk_irq(input string nm, input logic e);
      chk(nm, {31'h0, irq}, {31'h0, e});
   endtask

   // Count edges until irq rises (bounded); returns 99 if it never does
   task automatic wait_rise(output int n);
      n = 0;
      while (irq !== 1'b1 && n < 40) begin
         idle();
         n++;
      end
      if (irq !== 1'b1) n = 99;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [24:0] mask;
      logic [24:0] exp_mask;

      vecs[0]  = '{1'b0, 2'd0, 4'h0,    32'h0,         2'd0, 32'h0, 1'b0};
      vecs[1]  = '{1'b0, 2'd0, 4'h0,    32'h0,         2'd1, 32'h0, 1'b0};
      vecs[2]  = '{1'b0, 2'd0, 4'h0,    32'h0,         2'd2, 32'h0, 1'b0};
      vecs[3]  = '{1'b0, 2'd0, 4'h0,    32'h0,         2'd3, 32'h0, 1'b0};
      vecs[4]  = '{1'b1, 2'd1, 4'hF,    32'h1234_5678, 2'd1, 32'h1234_5678, 1'b0};
      vecs[5]  = '{1'b1, 2'd2, 4'hF,    32'hFFFF_FFFF, 2'd2, 32'h0, 1'b0};
      vecs[6]  = '{1'b1, 2'd3, 4'hF,    32'hDEAD_BEEF, 2'd3, 32'h0, 1'b0};
      vecs[7]  = '{1'b1, 2'd0, 4'hF,    32'hFFFF_FFF6, 2'd0, 32'h6, 1'b0};
      vecs[8]  = '{1'b1, 2'd0, 4'h0,    32'h0000_0001, 2'd0, 32'h6, 1'b0};
      vecs[9]  = '{1'b1, 2'd1, 4'h0,    32'h0,         2'd1, 32'h1234_5678, 1'b0};
      vecs[10] = '{1'b0, 2'd1, 4'hF,    32'h0,         2'd1, 32'h1234_5678, 1'b0};
      vecs[11] = '{1'b1, 2'd1, 4'hF,    32'h0,         2'd1, 32'h0, 1'b0};
      vecs[12] = '{1'b1, 2'd1, 4'b0001, 32'h0000_00AB, 2'd1, (BW ? 32'h0000_00AB : 32'h0), 1'b0};
      vecs[13] = '{1'b1, 2'd1, 4'b0100, 32'h00CD_0000, 2'd1, (BW ? 32'h00CD_00AB : 32'h0), 1'b0};
      vecs[14] = '{1'b1, 2'd0, 4'b0010, 32'h0000_0100, 2'd0, 32'h6, 1'b0};
      vecs[15] = '{1'b1, 2'd0, 4'b0001, 32'h0,         2'd0, (BW ? 32'h0 : 32'h6), 1'b0};
      vecs[16] = '{1'b1, 2'd0, 4'hF,    32'h0,         2'd0, 32'h0, 1'b0};
      vecs[17] = '{1'b1, 2'd1, 4'hF,    32'h0,         2'd1, 32'h0, 1'b0};

      // Reset held for two edges while the bus hammers writes
      reset = 1'b0; sel = 1'b1; addr = 2'd0; byteen = 4'hF; wdata = $urandom | 32'h1;
      @(posedge clk); #1;
      addr = 2'd1; wdata = $urandom;
      @(posedge clk); #1;
      @(negedge clk);
      reset = 1'b1; sel = 1'b0; byteen = 4'h0; wdata = 32'h0;

      // Register access table
      for (int i = 0; i < 18; i++) begin
         bus(vecs[i].sel, vecs[i].addr, vecs[i].be, vecs[i].wd);
         chk_rd($sformatf("vec%0d_rdata", i), vecs[i].rd_addr, vecs[i].exp_rd);
         chk_irq($sformatf("vec%0d_irq", i), vecs[i].exp_irq);
      end

      // One-shot: PRESET=5, irq rises 8 edges after the enabling write
      bus(1'b1, 2'd1, 4'hF, 32'd5);
      bus(1'b1, 2'd0, 4'hF, 32'h9);
      wait_rise(n);
      chk("os_rise_edges", n, 32'd8);
      idle();
      chk_rd("os_ctrl_en_cleared", 2'd0, 32'h8);
      chk_irq("os_irq_hold", 1'b1);
      idle(); idle(); idle();
      chk_irq("os_irq_hold_late", 1'b1);
      bus(1'b1, 2'd0, 4'hF, 32'h0);
      chk_irq("os_irq_cleared", 1'b0);

      // Auto-reload: PRESET=3, one-cycle pulse every 6 edges
      bus(1'b1, 2'd1, 4'hF, 32'd3);
      bus(1'b1, 2'd0, 4'hF, 32'hB);
      mask = '0;
      for (int k = 1; k <= 24; k++) begin
         idle();
         mask[k] = irq;
      end
      exp_mask = '0;
      exp_mask[6] = 1'b1; exp_mask[12] = 1'b1; exp_mask[18] = 1'b1; exp_mask[24] = 1'b1;
      chk("ar_pulse_pattern", {7'h0, mask}, {7'h0, exp_mask});
      bus(1'b1, 2'd0, 4'hF, 32'h0);
      idle(); idle(); idle();

      // COUNT is read-only while counting; IM=0 masks the interrupt
      bus(1'b1, 2'd1, 4'hF, 32'd4);
      bus(1'b1, 2'd0, 4'hF, 32'h1);
      idle(); idle();
      chk_rd("ro_count_n", 2'd2, 32'd4);
      bus(1'b1, 2'd2, 4'hF, 32'hFFFF_FFFF);
      chk_rd("ro_count_3", 2'd2, 32'd3);
      idle(); chk_rd("ro_count_2", 2'd2, 32'd2);
      idle(); chk_rd("ro_count_1", 2'd2, 32'd1);
      idle(); chk_rd("ro_count_0", 2'd2, 32'd0);
      idle();
      chk_irq("ro_irq_masked", 1'b0);
      chk_rd("ro_count_floor", 2'd2, 32'd0);
      idle();
      chk_rd("ro_ctrl_en_cleared", 2'd0, 32'h0);
      bus(1'b1, 2'd0, 4'hF, 32'h0);

      // Disable mid-count, then re-enable reloads PRESET
      bus(1'b1, 2'd1, 4'hF, 32'd10);
      bus(1'b1, 2'd0, 4'hF, 32'h1);
      n = 0;
      addr = 2'd2; #1;
      while (rdata !== 32'd7 && n < 30) begin
         idle();
         addr = 2'd2; #1;
         n++;
      end
      chk("dis_reach_7", rdata, 32'd7);
      bus(1'b1, 2'd0, 4'hF, 32'h0);
      chk_rd("dis_count_6", 2'd2, 32'd6);
      idle(); idle(); idle();
      chk_rd("dis_count_frozen", 2'd2, 32'd6);
      bus(1'b1, 2'd0, 4'hF, 32'h1);
      idle(); idle();
      chk_rd("dis_reload_10", 2'd2, 32'd10);
      bus(1'b1, 2'd0, 4'hF, 32'h0);
      idle(); idle();

      // PRESET=0: INT three edges after enable
      bus(1'b1, 2'd1, 4'hF, 32'd0);
      bus(1'b1, 2'd0, 4'hF, 32'h9);
      wait_rise(n);
      chk("p0_rise_edges", n, 32'd3);
      bus(1'b1, 2'd0, 4'hF, 32'h0);
      idle(); idle();

      // CTRL write on the edge irq_flag would set: clear wins
      bus(1'b1, 2'd1, 4'hF, 32'd2);
      bus(1'b1, 2'd0, 4'hF, 32'h9);
      idle(); idle(); idle(); idle();
      chk_irq("cs_pre", 1'b0);
      bus(1'b1, 2'd0, 4'hF, 32'h9);
      chk_irq("cs_clear_wins", 1'b0);
      idle();
      chk_irq("cs_still_clear", 1'b0);
      chk_rd("cs_ctrl_after_int", 2'd0, 32'h8);
      bus(1'b1, 2'd0, 4'hF, 32'h0);

      // CTRL write on the INT auto-clear edge: written value kept
      bus(1'b1, 2'd1, 4'hF, 32'd1);
      bus(1'b1, 2'd0, 4'hF, 32'h9);
      idle(); idle(); idle(); idle();
      chk_irq("ww_int", 1'b1);
      bus(1'b1, 2'd0, 4'hF, 32'h9);
      chk_rd("ww_ctrl_kept", 2'd0, 32'h9);
      chk_irq("ww_irq_cleared", 1'b0);
      wait_rise(n);
      chk("ww_rerun_edges", n, 32'd4);
      bus(1'b1, 2'd0, 4'hF, 32'h0);
      idle(); idle();

      // MODE 2 behaves as one-shot
      bus(1'b1, 2'd1, 4'hF, 32'd1);
      bus(1'b1, 2'd0, 4'hF, 32'hD);
      wait_rise(n);
      chk("m2_rise_edges", n, 32'd4);
      idle();
      chk_rd("m2_ctrl_en_cleared", 2'd0, 32'hC);
      chk_irq("m2_irq_hold", 1'b1);
      bus(1'b1, 2'd0, 4'hF, 32'h0);

      // Reset mid-count
      bus(1'b1, 2'd1, 4'hF, 32'h20);
      bus(1'b1, 2'd0, 4'hF, 32'h9);
      idle(); idle(); idle();
      @(negedge clk);
      reset = 1'b0; sel = 1'b1; addr = 2'd1; byteen = 4'hF; wdata = 32'h55;
      @(posedge clk); #1;
      reset = 1'b1; sel = 1'b0; byteen = 4'h0; wdata = 32'h0;
      chk_rd("rst_ctrl", 2'd0, 32'h0);
      chk_rd("rst_preset", 2'd1, 32'h0);
      chk_rd("rst_count", 2'd2, 32'h0);
      chk_irq("rst_irq", 1'b0);
      idle(); idle(); idle();
      chk_rd("rst_count_idle", 2'd2, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
